// File: rtl/clint_responder.sv
// Core-local interruptor: mtime, mtimecmp and msip behind the data bus.
// Drives the machine timer and software interrupt lines.
module clint_responder #(
  parameter logic [31:0] BASE     = 32'h0200_0000,
  parameter int          TICK_DIV = 27
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        timer_irq,
  output logic        soft_irq
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc, presc_n;
  logic [63:0]   mtime, mtimecmp, cmp_n;
  logic [31:0]   lo_n, hi_n, rdata;
  logic          msip, msip_n, tick;
  logic [15:0]   off;
  logic          sel_msip, sel_cmp_lo, sel_cmp_hi;
  logic          sel_tm_lo, sel_tm_hi;
  logic          unused_addr;

  // Low 16 bits of the difference only depend on the low 16 address bits
  assign off         = addr[15:0] - BASE[15:0];
  assign unused_addr = ^addr[31:16];

  assign sel_msip   = (off == 16'h0000);
  assign sel_cmp_lo = (off == 16'h4000);
  assign sel_cmp_hi = (off == 16'h4004);
  assign sel_tm_lo  = (off == 16'hBFF8);
  assign sel_tm_hi  = (off == 16'hBFFC);

  assign tick = (presc == PMAX);

  always_comb begin
    presc_n = tick ? '0 : presc + 1'b1;
    lo_n    = mtime[31:0] + {31'd0, tick};
    hi_n    = mtime[63:32] + {31'd0, tick & (&mtime[31:0])};
    cmp_n   = mtimecmp;
    msip_n  = msip;
    // A write to one mtime half wins over the tick; carry is dropped
    if (wen && sel_tm_lo) begin
      lo_n = data_in;
      hi_n = mtime[63:32];
    end
    if (wen && sel_tm_hi)  hi_n          = data_in;
    if (wen && sel_cmp_lo) cmp_n[31:0]   = data_in;
    if (wen && sel_cmp_hi) cmp_n[63:32]  = data_in;
    if (wen && sel_msip)   msip_n        = data_in[0];
  end

  always_comb begin
    rdata = '0;
    unique case (1'b1)
      sel_msip:   rdata = {31'd0, msip};
      sel_cmp_lo: rdata = mtimecmp[31:0];
      sel_cmp_hi: rdata = mtimecmp[63:32];
      sel_tm_lo:  rdata = mtime[31:0];
      sel_tm_hi:  rdata = mtime[63:32];
      default:    rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc     <= '0;
      mtime     <= '0;
      mtimecmp  <= '1;
      msip      <= 1'b0;
      data_out  <= '0;
      timer_irq <= 1'b0;
      soft_irq  <= 1'b0;
    end else begin
      presc     <= presc_n;
      mtime     <= {hi_n, lo_n};
      mtimecmp  <= cmp_n;
      msip      <= msip_n;
      timer_irq <= ({hi_n, lo_n} >= cmp_n);
      soft_irq  <= msip_n;
      if (ren) data_out <= rdata;
    end
  end

endmodule

// File: tb/tb_clint_responder.sv
// Bench for clint_responder: TICK_DIV=4 and TICK_DIV=1 instances
// share one bus; reads are scored through an expectation queue.
module tb_clint_responder;

  localparam logic [31:0] BASE = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] data_out4, data_out1;
  logic        timer_irq4, timer_irq1;
  logic        soft_irq4, soft_irq1;

  always #5 clk = ~clk;

  clint_responder #(.BASE(BASE), .TICK_DIV(4)) u_dut4 (
    .clk(clk), .reset(reset), .addr(addr), .ren(ren), .wen(wen),
    .data_in(data_in), .data_out(data_out4),
    .timer_irq(timer_irq4), .soft_irq(soft_irq4)
  );

  clint_responder #(.BASE(BASE), .TICK_DIV(1)) u_dut1 (
    .clk(clk), .reset(reset), .addr(addr), .ren(ren), .wen(wen),
    .data_in(data_in), .data_out(data_out1),
    .timer_irq(timer_irq1), .soft_irq(soft_irq1)
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
    bit          which;
  } sb_t;

  typedef struct {
    string       name;
    logic        r;
    logic        w;
    logic [15:0] off;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  sb_t  sbq[$];
  vec_t t1[3];
  vec_t t6[8];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] ba(input logic [15:0] o);
    return BASE + {16'd0, o};
  endfunction

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  // One bus cycle; a read pushes its expectation and is scored after the edge
  task automatic cycle(input logic r, input logic w,
                       input logic [15:0] o, input logic [31:0] d,
                       input bit which, input string n,
                       input logic [31:0] exp);
    sb_t e;
    ren = r;
    wen = w;
    addr = ba(o);
    data_in = d;
    if (r) sbq.push_back('{n, exp, which});
    @(posedge clk);
    #1;
    ren = 1'b0;
    wen = 1'b0;
    if (r) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s: scoreboard empty", n);
      end else begin
        e = sbq.pop_front();
        chk(e.name, e.which ? data_out1 : data_out4, e.exp);
      end
    end
  endtask

  task automatic wr(input logic [15:0] o, input logic [31:0] d);
    cycle(1'b0, 1'b1, o, d, 1'b0, "", 32'h0);
  endtask

  task automatic rd(input bit which, input logic [15:0] o,
                    input logic [31:0] exp, input string n);
    cycle(1'b1, 1'b0, o, 32'h0, which, n, exp);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'b0, 16'h0, 32'h0, 1'b0, "", 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    t1[0] = '{"rst_cmp_lo", 1'b1, 1'b0, 16'h4000, 32'h0, 32'hFFFF_FFFF};
    t1[1] = '{"rst_cmp_hi", 1'b1, 1'b0, 16'h4004, 32'h0, 32'hFFFF_FFFF};
    t1[2] = '{"rst_mtime",  1'b1, 1'b0, 16'hBFF8, 32'h0, 32'h0};

    t6[0] = '{"unmap_rd",  1'b1, 1'b0, 16'h1234, 32'h0, 32'h0};
    t6[1] = '{"unmap_wr",  1'b0, 1'b1, 16'h1234, 32'hDEAD_BEEF, 32'h0};
    t6[2] = '{"post_clo",  1'b1, 1'b0, 16'h4000, 32'h0, 32'hFFFF_FFFF};
    t6[3] = '{"post_chi",  1'b1, 1'b0, 16'h4004, 32'h0, 32'hFFFF_FFFF};
    t6[4] = '{"post_msip", 1'b1, 1'b0, 16'h0000, 32'h0, 32'h0};
    t6[5] = '{"unmap_rd2", 1'b1, 1'b0, 16'h1234, 32'h0, 32'h0};
    t6[6] = '{"post_mhi",  1'b1, 1'b0, 16'hBFFC, 32'h0, 32'h0};
    t6[7] = '{"post_mlo",  1'b1, 1'b0, 16'hBFF8, 32'h0, 32'h7};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_dout", data_out4, 32'h0);
    reset = 1'b0;

    foreach (t1[i])
      cycle(t1[i].r, t1[i].w, t1[i].off, t1[i].d, 1'b0,
            t1[i].name, t1[i].exp);
    chk("rst_tirq", {31'd0, timer_irq4}, 32'h0);
    chk("rst_sirq", {31'd0, soft_irq4}, 32'h0);

    idle(37);
    rd(1'b0, 16'hBFF8, 32'd10, "tick_41");
    rd(1'b0, 16'hBFF8, 32'd10, "tick_42");
    rd(1'b0, 16'hBFF8, 32'd10, "tick_43");
    rd(1'b0, 16'hBFF8, 32'd10, "tick_44");
    rd(1'b0, 16'hBFF8, 32'd11, "tick_45");

    wr(16'hBFFC, 32'h0);
    wr(16'hBFF8, 32'h0);
    wr(16'h4004, 32'h0);
    wr(16'h4000, 32'd20);
    chk("irq_cmp_set", {31'd0, timer_irq1}, 32'h0);
    idle(17);
    chk("irq_at_19", {31'd0, timer_irq1}, 32'h0);
    idle(1);
    chk("irq_at_20", {31'd0, timer_irq1}, 32'h1);
    wr(16'h4000, 32'd1000);
    chk("irq_clear", {31'd0, timer_irq1}, 32'h0);

    wr(16'hBFFC, 32'h0);
    wr(16'hBFF8, 32'hFFFF_FFFE);
    idle(2);
    rd(1'b1, 16'hBFF8, 32'h0, "carry_lo");
    rd(1'b1, 16'hBFFC, 32'h1, "carry_hi");

    wr(16'hBFFC, 32'hFFFF_FFFF);
    wr(16'hBFF8, 32'hFFFF_FFFF);
    chk("max_irq", {31'd0, timer_irq1}, 32'h1);
    idle(1);
    chk("wrap_irq", {31'd0, timer_irq1}, 32'h0);
    rd(1'b1, 16'hBFF8, 32'h0, "wrap_lo");
    rd(1'b1, 16'hBFFC, 32'h0, "wrap_hi");

    wr(16'hBFFC, 32'h7);
    wr(16'hBFF8, 32'hFFFF_FFFE);
    idle(1);
    wr(16'hBFF8, 32'h5);
    rd(1'b1, 16'hBFF8, 32'h5, "coll_lo");
    rd(1'b1, 16'hBFFC, 32'h7, "coll_lo_hi");

    wr(16'hBFF8, 32'hFFFF_FFFE);
    idle(1);
    wr(16'hBFFC, 32'h9);
    rd(1'b1, 16'hBFFC, 32'h9, "coll_hi");
    rd(1'b1, 16'hBFF8, 32'h1, "coll_hi_lo");

    chk("sirq_pre", {31'd0, soft_irq1}, 32'h0);
    cycle(1'b1, 1'b1, 16'h0000, 32'h1, 1'b1, "msip_rw", 32'h0);
    chk("sirq_set", {31'd0, soft_irq1}, 32'h1);
    rd(1'b1, 16'h0000, 32'h1, "msip_rd");

    wr(16'h4004, 32'h0);
    wr(16'h4000, 32'h0);
    chk("irq_cmp0", {31'd0, timer_irq1}, 32'h1);

    reset = 1'b1;
    ren = 1'b1;
    addr = ba(16'h4000);
    @(posedge clk);
    #1;
    ren = 1'b0;
    chk("mid_dout", data_out1, 32'h0);
    chk("mid_tirq", {31'd0, timer_irq1}, 32'h0);
    chk("mid_sirq", {31'd0, soft_irq1}, 32'h0);
    chk("mid_dout4", data_out4, 32'h0);
    reset = 1'b0;

    foreach (t6[i])
      cycle(t6[i].r, t6[i].w, t6[i].off, t6[i].d, 1'b1,
            t6[i].name, t6[i].exp);
    chk("post_sirq", {31'd0, soft_irq1}, 32'h0);
    chk("sb_drained", sbq.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clint_responder.md
Name: clint_responder

Overview:
- Memory-mapped core-local interruptor (CLINT) slave on the data bus, and the responder for the bus decoder's clint_ren/clint_wen/clint_data_out path.
- Holds the 64-bit mtime counter, the 64-bit mtimecmp compare register and the msip software-interrupt bit.
- Drives the machine timer and software interrupt lines into the core's trap logic.
- Word accesses only; all sub-word, byte-enable and alignment handling is upstream.

Parameters:
- BASE, 32'h0200_0000, CLINT_START address; the offset is addr minus BASE, low 16 bits.
- TICK_DIV, 27, clk cycles per mtime increment (27 MHz clk gives a 1 MHz mtime); must be at least 1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- addr  in  32  bus data address (data_addr).
- ren  in  1  read strobe from the bus decoder (clint_ren).
- wen  in  1  write strobe from the bus decoder (clint_wen).
- data_in  in  32  write data.
- data_out  out  32  registered read data (clint_data_out).
- timer_irq  out  1  machine timer interrupt, level.
- soft_irq  out  1  machine software interrupt, level (msip bit 0).

Behaviour:
- Register map, by offset:
  - 0x0000 msip: bit0 is R/W, bits 31:1 read 0.
  - 0x4000 mtimecmp[31:0], 0x4004 mtimecmp[63:32]: R/W.
  - 0xBFF8 mtime[31:0], 0xBFFC mtime[63:32]: R/W.
  - Any other offset reads 0; writes to it are ignored.
- Reset values: mtime=0, mtimecmp=64'hFFFF_FFFF_FFFF_FFFF, msip=0, prescaler=0, data_out=0, timer_irq=0, soft_irq=0.
- Reset applies mid-operation and overrides any ren/wen in the same cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - The cycle it wraps is a tick: mtime <= mtime+1.
  - mtime wraps 64'hFFFF_FFFF_FFFF_FFFF -> 0 with no flag.
  - TICK_DIV=1 means a tick every cycle.
- Writes (wen=1) take effect at the clock edge; the new value is visible from the next cycle.
- Write colliding with a tick:
  - Write to mtime low: low <= data_in; high unchanged (no carry that cycle).
  - Write to mtime high: high <= data_in; low increments normally; any carry out of low is dropped that cycle.
  - The prescaler is never reset by mtime writes.
- Reads, 1-cycle latency:
  - If ren=1 at edge N, data_out after edge N holds the register value before edge N.
  - ren and wen together in one cycle: the write is performed and the read returns the pre-write value.
  - data_out holds its last value while ren=0.
- timer_irq:
  - Registered; timer_irq <= (mtime >= mtimecmp) using the post-update values of both.
  - It therefore asserts on the same edge that mtime reaches mtimecmp or that mtimecmp is written at or below mtime.
  - Unsigned 64-bit compare.
  - Level, not sticky: clears on the edge after software raises mtimecmp above mtime.
- soft_irq:
  - soft_irq <= msip bit written; it tracks msip directly as a register output.
  - Writing 0x1 sets it; writing 0x0 clears it.
- Partial mtimecmp updates are not atomic. Software writes the high word as all ones first; the hardware gives no extra protection.

Test Plan:
1. Reset values, TICK_DIV=4:
   - Stimulus: reset for 2 cycles, then read 0x4000, 0x4004, 0xBFF8.
   - Required: data_out = FFFF_FFFF, FFFF_FFFF, 0; timer_irq=0; soft_irq=0.
2. Tick rate, TICK_DIV=4:
   - Stimulus: run 40 cycles after reset release, then read 0xBFF8.
   - Required: mtime low = 10 (±1 per sampling phase); ticks exactly every 4th cycle.
3. Timer interrupt, TICK_DIV=1:
   - Stimulus: write 0x4004=0, then 0x4000=20 while mtime is below 20.
   - Required: timer_irq rises on the edge mtime becomes 20.
   - Then write 0x4000=1000: timer_irq falls on that edge.
4. Carry and rollover, TICK_DIV=1:
   - Stimulus: write 0xBFFC=0, then 0xBFF8=FFFF_FFFE.
   - Required: after 2 ticks, high=1 and low=0.
   - Stimulus: write high and low to FFFF_FFFF.
   - Required: after 1 tick, mtime=0.
5. Collision, TICK_DIV=1:
   - Stimulus: write 0xBFF8=5 on a tick cycle.
   - Required: next-cycle mtime low=5, high unchanged.
   - Stimulus: ren+wen to 0x0000 with data 1 while msip=0.
   - Required: data_out=0; soft_irq=1 next cycle.
6. Mid-operation reset and unmapped offsets:
   - Stimulus: assert reset with timer_irq=1 and msip=1 while ren=1.
   - Required: on the next edge all state returns to reset values, including data_out=0.
   - Stimulus: read 0x1234.
   - Required: data_out=0.
   - Stimulus: write 0x1234=0xDEAD_BEEF.
   - Required: no register changes.
